// File: rtl/eeprom_pkg.sv
// Shared types and defaults for the EEPROM request sequencer.
package eeprom_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ERASE  = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        VERIFY = 3'd4,
        RESP   = 3'd5
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } req_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/eeprom_ctrl.sv
// Request sequencer for the 16x16 EEPROM macro: read, and program as erase+write.
// Define EEPROM_VERIFY_EN to add a readback-verify phase after every program.
module eeprom_ctrl
    import eeprom_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ERASE_CYC = 1,
    parameter int WRITE_CYC = 1,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ee_addr,
    output logic              ee_we,
    output logic              ee_erase,
    output logic [DATA_W-1:0] ee_data_in,
    input  logic [DATA_W-1:0] ee_data_out
);

    localparam int CNT_W = $clog2(max3(ERASE_CYC, WRITE_CYC, READ_LAT)) + 1;
    localparam logic [CNT_W-1:0] ERASE_LD = CNT_W'(ERASE_CYC - 1);
    localparam logic [CNT_W-1:0] WRITE_LD = CNT_W'(WRITE_CYC - 1);
    localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    req_t             req_q;

    // The latched address is the pin: it stays put from accept until the next accept.
    assign ee_addr = req_q.addr;

`ifndef EEPROM_VERIFY_EN
    assign rsp_err = 1'b0;
`endif

    // NOTE: every state and output flop updates with <= so all of them see the
    // same pre-edge values; mixing in blocking writes would make order matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_q      <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            ee_we      <= 1'b0;
            ee_erase   <= 1'b0;
            ee_data_in <= '0;
`ifdef EEPROM_VERIFY_EN
            rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q     <= '{write: req_write, addr: req_addr, data: req_data};
                        req_ready <= 1'b0;
                        if (req_write) begin
                            state    <= ERASE;
                            ee_erase <= 1'b1;
                            cnt      <= ERASE_LD;
                        end else begin
                            state <= READ;
                            cnt   <= READ_LD;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                ERASE: begin
                    if (cnt == '0) begin
                        state      <= WRITE;
                        ee_erase   <= 1'b0;
                        ee_we      <= 1'b1;
                        ee_data_in <= req_q.data;
                        cnt        <= WRITE_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

`ifdef EEPROM_VERIFY_EN
                WRITE: begin
                    if (cnt == '0) begin
                        state <= VERIFY;
                        ee_we <= 1'b0;
                        cnt   <= READ_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // Only a program can reach VERIFY, so the write bit gates the compare.
                READ, VERIFY: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= ee_data_out;
                        rsp_err   <= req_q.write && (ee_data_out != req_q.data);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`else
                // Program reports the data it wrote; read reports what the macro returns.
                WRITE, READ: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        ee_we     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= req_q.write ? req_q.data : ee_data_out;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif

                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    ee_we    <= 1'b0;
                    ee_erase <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_ctrl.sv
// Self-checking bench for eeprom_ctrl driving a behavioural 16x16 EEPROM model.
// Honours EEPROM_VERIFY_EN the same way the design does.
module tb_eeprom_ctrl;

    localparam int READ_LATENCY = 2;
`ifdef EEPROM_VERIFY_EN
    localparam int PROG_LATENCY = 4;
    localparam bit VERIFY_ON    = 1'b1;
`else
    localparam int PROG_LATENCY = 3;
    localparam bit VERIFY_ON    = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  ee_addr;
    logic        ee_we;
    logic        ee_erase;
    logic [15:0] ee_data_in;
    logic [15:0] ee_data_out;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];

    logic [15:0] mem [16];
    logic [15:0] shadow [16];
    logic        mem_loaded = 1'b0;
    logic        stuck0     = 1'b0;

    eeprom_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .ee_addr    (ee_addr),
        .ee_we      (ee_we),
        .ee_erase   (ee_erase),
        .ee_data_in (ee_data_in),
        .ee_data_out(ee_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // EEPROM model: erase sets the word to all ones, write stores data_in, read is
    // combinational; stuck0 models a bit-0 stuck-at-0 fault on the read path.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'hA500 | 16'(i);
            mem_loaded <= 1'b1;
        end else if (ee_erase) begin
            mem[ee_addr] <= 16'hFFFF;
        end else if (ee_we) begin
            mem[ee_addr] <= ee_data_in;
        end
    end
    assign ee_data_out = mem[ee_addr] & (stuck0 ? 16'hFFFE : 16'hFFFF);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pin invariants watched every cycle while out of reset.
    logic [15:0] prev_din = '0;
    logic        prev_rst = 1'b0;
    always @(negedge clk) begin
        if (rst_n && prev_rst) begin
            check("we_and_erase", ee_we && ee_erase, 0);
            if (ee_data_in !== prev_din) check("din_change_at_write", ee_we, 1);
        end
        prev_din <= ee_data_in;
        prev_rst <= rst_n;
    end

    function automatic logic [15:0] read_back(input logic [15:0] d);
        return stuck0 ? (d & 16'hFFFE) : d;
    endfunction

    // One request from a negedge through its response handshake; leaves req_valid
    // high when keep_valid is set so the next call continues a held request stream.
    task automatic txn(input logic w, input logic [3:0] a, input logic [15:0] d,
                       input int hold, input bit keep_valid);
        int          n, acc, er_c, we_c, exp_lat;
        bit          addr_ok, busy_ok;
        logic [15:0] din_seen, d0, obs_d;
        logic        obs_e;
        exp_t        e;

        req_write = w;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", n < 20, 1);
        acc = cyc + 1;

        if (w) begin
            shadow[a] = d;
            e.data = VERIFY_ON ? read_back(d) : d;
            e.err  = VERIFY_ON && (read_back(d) != d);
            exp_lat = PROG_LATENCY;
        end else begin
            e.data = read_back(shadow[a]);
            e.err  = 1'b0;
            exp_lat = READ_LATENCY;
        end
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (!keep_valid) req_valid = 1'b0;

        er_c = 0; we_c = 0; din_seen = '0; addr_ok = 1; busy_ok = 1; n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            if (ee_erase) er_c++;
            if (ee_we) begin
                we_c++;
                din_seen = ee_data_in;
            end
            if (ee_addr !== a) addr_ok = 0;
            if (req_ready !== 1'b0) busy_ok = 0;
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", n < 20, 1);
        check("latency", cyc - acc + 1, exp_lat);
        check("erase_cycles", er_c, w ? 1 : 0);
        check("we_cycles", we_c, w ? 1 : 0);
        if (w) check("ee_data_in", din_seen, d);

        d0 = rsp_data;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, d0);
            if (ee_addr !== a) addr_ok = 0;
            if (req_ready !== 1'b0) busy_ok = 0;
        end
        check("addr_stable", addr_ok, 1);
        check("ready_low_busy", busy_ok, 1);

        rsp_ready = 1'b1;
        obs_d = rsp_data;
        obs_e = rsp_err;
        @(posedge clk);
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_data", obs_d, e.data);
            check("rsp_err", obs_e, e.err);
        end
        @(negedge clk);
        check("rsp_valid_drop", rsp_valid, 0);
        check("ready_after_rsp", req_ready, 1);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 16; i++) shadow[i] = 16'hA500 | 16'(i);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_outputs", {rsp_data, rsp_err, ee_addr, ee_we, ee_erase, ee_data_in}, 0);

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_before_edge", req_ready, 0);
        @(negedge clk);
        check("ready_first_edge", req_ready, 1);

        // Program then read back.
        txn(1'b1, 4'd7, 16'h00AA, 0, 1'b0);
        txn(1'b0, 4'd7, 16'h0000, 0, 1'b0);

        // Back-to-back programs with req_valid held high, then read them back.
        txn(1'b1, 4'd9,  16'h00BB, 0, 1'b1);
        txn(1'b1, 4'd11, 16'h00CC, 0, 1'b1);
        txn(1'b1, 4'd13, 16'h00DD, 0, 1'b0);
        txn(1'b0, 4'd9,  16'h0000, 0, 1'b0);
        txn(1'b0, 4'd11, 16'h0000, 0, 1'b0);
        txn(1'b0, 4'd13, 16'h0000, 0, 1'b0);

        // Response backpressure.
        txn(1'b0, 4'd9, 16'h0000, 3, 1'b0);

        // Reset in the middle of an erase: request is dropped, memory untouched.
        req_write = 1'b1;
        req_addr  = 4'd3;
        req_data  = 16'h1234;
        req_valid = 1'b1;
        check("rst_test_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("erase_started", ee_erase, 1);
        check("erase_addr", ee_addr, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_erase_drop", ee_erase, 0);
        check("async_outputs", {req_ready, rsp_valid, rsp_data, rsp_err, ee_addr, ee_we, ee_data_in}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("no_rsp_after_reset", seen, 0);
        check("ready_after_reset", req_ready, 1);
        txn(1'b0, 4'd3, 16'h0000, 0, 1'b0);

        // Program verify: faulty read path then healthy one.
`ifdef EEPROM_VERIFY_EN
        stuck0 = 1'b1;
        txn(1'b1, 4'd5, 16'h0001, 0, 1'b0);
        stuck0 = 1'b0;
`endif
        txn(1'b1, 4'd5, 16'h0001, 0, 1'b0);
        txn(1'b0, 4'd5, 16'h0000, 0, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
